// File: rtl/instruction_loader.sv
// instruction_loader: boot loader packing a little-endian byte stream into 32-bit words for instruction memory.
// Optional trailing 8-bit checksum enabled by defining INSTRUCTION_LOADER_CHECKSUM_EN.
// MEM_ADDR_WIDTH defaults to `MEM_ADDR_WIDTH when defined, else 8.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 8
`endif
module instruction_loader #(
  parameter int MEM_ADDR_WIDTH = `MEM_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [7:0]                in_data,
  output logic                      in_ready,
  input  logic                      start,
  output logic                      load_en,
  output logic [MEM_ADDR_WIDTH-1:0] load_addr,
  output logic [31:0]               load_data,
  output logic                      cpu_rst_n,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);
  typedef enum logic [2:0] {
    IDLE, HDR0, HDR1, DATA,
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE, ERR
  } state_t;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  localparam state_t FIN = CHK;
`else
  localparam state_t FIN = DONE;
`endif
  state_t                    state_q, state_d;
  logic [15:0]               cnt_q, cnt_d;
  logic [15:0]               idx_q, idx_d;
  logic [1:0]                byte_q, byte_d;
  logic [31:0]               word_q, word_d;
  logic                      load_en_q, load_en_d;
  logic [MEM_ADDR_WIDTH-1:0] load_addr_q, load_addr_d;
  logic [31:0]               load_data_q, load_data_d;
  logic                      acc;
  logic                      oversize;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  logic [7:0]                sum_q, sum_d;
`endif
  assign in_ready  = state_q inside {HDR0, HDR1, DATA, FIN} && state_q != DONE;
  assign busy      = in_ready;
  assign done      = state_q == DONE;
  assign cpu_rst_n = state_q == DONE;
  assign error     = state_q == ERR;
  assign load_en   = load_en_q;
  assign load_addr = load_addr_q;
  assign load_data = load_data_q;
  assign acc       = in_valid && in_ready;
  assign oversize  = 32'({in_data, cnt_q[7:0]}) > (32'd1 << MEM_ADDR_WIDTH);
  // next-state: header capture, word packing (new bytes shift in from the top), write issue
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    byte_d      = byte_q;
    word_d      = word_q;
    load_en_d   = 1'b0;
    load_addr_d = load_addr_q;
    load_data_d = load_data_q;
    case (state_q)
      IDLE: begin
        state_d = HDR0;
        idx_d   = '0;
        byte_d  = '0;
      end
      HDR0: if (acc) begin
        cnt_d[7:0] = in_data;
        state_d    = HDR1;
      end
      HDR1: if (acc) begin
        cnt_d[15:8] = in_data;
        state_d     = oversize ? ERR : ({in_data, cnt_q[7:0]} == 16'd0) ? FIN : DATA;
      end
      DATA: if (acc) begin
        byte_d = byte_q + 2'd1;
        word_d = {in_data, word_q[31:8]};
        if (byte_q == 2'd3) begin
          load_en_d   = 1'b1;
          load_addr_d = MEM_ADDR_WIDTH'(idx_q);
          load_data_d = {in_data, word_q[31:8]};
          idx_d       = idx_q + 16'd1;
          state_d     = (idx_q == cnt_q - 16'd1) ? FIN : DATA;
        end
      end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      CHK: if (acc) state_d = (in_data == sum_q) ? DONE : ERR;
`endif
      DONE, ERR: if (start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  // running sum of every byte before the checksum byte, cleared on each new load
  always_comb begin
    sum_d = sum_q;
    if (state_q == IDLE) sum_d = '0;
    else if (acc && state_q != CHK) sum_d = sum_q + in_data;
  end
`endif
  // state and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      byte_q      <= '0;
      word_q      <= '0;
      load_en_q   <= 1'b0;
      load_addr_q <= '0;
      load_data_q <= '0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      byte_q      <= byte_d;
      word_q      <= word_d;
      load_en_q   <= load_en_d;
      load_addr_q <= load_addr_d;
      load_data_q <= load_data_d;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: randomized scoreboard bench for instruction_loader (checksum mode follows INSTRUCTION_LOADER_CHECKSUM_EN)
module tb_instruction_loader;
  localparam int AW = 4;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          start = 1'b0;
  logic          in_ready, load_en, cpu_rst_n, busy, done, error;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  int            vectors = 0;
  int            miscompares = 0;
  logic [AW+31:0] sb[$];

  always #5 clk = ~clk;

  instruction_loader #(.MEM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .start(start), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .error(error)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every memory write must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n && load_en) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", load_addr, load_data);
      end else begin
        logic [AW+31:0] e;
        e = sb.pop_front();
        if ({load_addr, load_data} !== e) begin
          miscompares++;
          $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                   load_addr, load_data, e[AW+31:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] b, input bit gaps);
    bit acc;
    if (gaps && $urandom_range(2) == 0) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; ; t++) begin
      acc = in_ready;
      @(negedge clk);
      if (acc) break;
      if (t == 30) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
  endtask

  // reference model: builds the stream, predicted writes and final status from the format rules
  task automatic run(input int n, input logic [31:0] w[$], input bit gaps, input int ck_delta);
    logic [7:0] s[$];
    logic [7:0] sum;
    bit over, exp_err;
    s.push_back(n[7:0]);
    s.push_back(n[15:8]);
    over = n > (1 << AW);
    exp_err = over;
    if (!over)
      for (int i = 0; i < n; i++) begin
        for (int k = 0; k < 4; k++) s.push_back(w[i][8*k +: 8]);
        sb.push_back({AW'(i), w[i]});
      end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    if (!over) begin
      sum = '0;
      foreach (s[i]) sum = sum + s[i];
      s.push_back(sum + 8'(ck_delta));
      exp_err = ck_delta != 0;
    end
`endif
    foreach (s[i]) send(s[i], gaps);
    in_valid = 1'b0;
    check("done", done, !exp_err);
    check("error", error, exp_err);
    check("cpu_rst_n", cpu_rst_n, !exp_err);
    check("in_ready_end", in_ready, 0);
    check("busy_end", busy, 0);
    @(negedge clk);
    check("writes_drained", sb.size(), 0);
  endtask

  task automatic rearm();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rearm_done", done, 0);
    check("rearm_error", error, 0);
    check("rearm_cpu_rst_n", cpu_rst_n, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_load_en"}, load_en, 0);
    check({tag, "_load_addr"}, load_addr, 0);
    check({tag, "_load_data"}, load_data, 0);
    check({tag, "_cpu_rst_n"}, cpu_rst_n, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
  endtask

  initial begin
    logic [31:0] img[$];
    logic [31:0] rnd[$];
    logic [31:0] none[$];
    img.push_back(32'h0000_0013);
    img.push_back(32'hDEAD_BEEF);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    run(2, img, 1'b0, 0);
    rearm();
    run(2, img, 1'b1, 0);
    rearm();
    run(0, none, 1'b1, 0);
    rearm();
    run((1 << AW) + 1, none, 1'b0, 0);
    rearm();
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    run(2, img, 1'b0, 1);
    rearm();
    run(2, img, 1'b1, 0);
    rearm();
`endif
    for (int i = 0; i < (1 << AW); i++) rnd.push_back($urandom);
    run(1 << AW, rnd, 1'b1, 0);
    rearm();
    send(8'h02, 1'b0);
    send(8'h00, 1'b0);
    sb.push_back({AW'(0), img[0]});
    for (int k = 0; k < 4; k++) send(img[0][8*k +: 8], 1'b0);
    send(img[1][7:0], 1'b0);
    send(img[1][15:8], 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midload_reset");
    check("midload_writes", sb.size(), 0);
    rst_n = 1'b1;
    run(2, img, 1'b1, 0);
    for (int r = 0; r < 4; r++) begin
      rnd.delete();
      rearm();
      for (int i = 0, n = $urandom_range(1, 8); i < n; i++) rnd.push_back($urandom);
      run(rnd.size(), rnd, 1'b1, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
